// File: rtl/tff_counter_bank.sv
// WIDTH-bit register bank: per-bit T/D/set/clear flip-flops or a single modulo
// up/down counter, with clock enable, terminal-count pulse and sticky overflow.
module tff_counter_bank #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MODULO    = 256,
    parameter bit              SATURATE  = 1'b0,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0]   MAX_X = MOD_X - 1'b1;
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    localparam logic [2:0] M_HOLD   = 3'b000;
    localparam logic [2:0] M_LOAD   = 3'b001;
    localparam logic [2:0] M_TOGGLE = 3'b010;
    localparam logic [2:0] M_CLEAR  = 3'b011;
    localparam logic [2:0] M_SET    = 3'b100;
    localparam logic [2:0] M_UP     = 3'b101;
    localparam logic [2:0] M_DOWN   = 3'b110;
    localparam logic [2:0] M_ROT    = 3'b111;

    typedef struct packed {
        logic             ev;
        logic [WIDTH-1:0] q;
    } step_t;

    // Counting is done one bit wider than Q so that MODULO = 2^WIDTH and
    // out-of-range loaded values compare correctly.
    function automatic step_t count_up(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] x;
        logic [WIDTH:0] s;
        step_t          r;
        x = {1'b0, cur};
        s = x + 1'b1;
        if (x < MAX_X) begin
            r.ev = 1'b0;
            r.q  = s[WIDTH-1:0];
        end else begin
            r.ev = 1'b1;
            r.q  = SATURATE ? MAX_X[WIDTH-1:0] : '0;
        end
        return r;
    endfunction

    function automatic step_t count_down(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] x;
        logic [WIDTH:0] s;
        step_t          r;
        x = {1'b0, cur};
        s = x - 1'b1;
        if (x == '0) begin
            r.ev = 1'b1;
            r.q  = SATURATE ? '0 : MAX_X[WIDTH-1:0];
        end else if (x < MOD_X) begin
            r.ev = 1'b0;
            r.q  = s[WIDTH-1:0];
        end else begin
            // Out-of-range value: clamp to the top; only a wrap counts as an event.
            r.ev = ~SATURATE;
            r.q  = MAX_X[WIDTH-1:0];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] q_rot;
    step_t            up_r;
    step_t            dn_r;
    logic [WIDTH-1:0] q_nxt;
    logic             ev;

    generate
        if (WIDTH == 1) begin : g_rot1
            assign q_rot = Q;
        end else begin : g_rotn
            assign q_rot = {Q[WIDTH-2:0], Q[WIDTH-1]};
        end
    endgenerate

    assign up_r = count_up(Q);
    assign dn_r = count_down(Q);

    always_comb begin
        q_nxt = Q;
        ev    = 1'b0;
        case (MODE)
            M_HOLD:   q_nxt = Q;
            M_LOAD:   q_nxt = D;
            M_TOGGLE: q_nxt = Q ^ D;
            M_CLEAR:  q_nxt = Q & ~D;
            M_SET:    q_nxt = Q | D;
            M_UP: begin
                q_nxt = up_r.q;
                ev    = up_r.ev;
            end
            M_DOWN: begin
                q_nxt = dn_r.q;
                ev    = dn_r.ev;
            end
            M_ROT:    q_nxt = q_rot;
            default:  q_nxt = Q;
        endcase
    end

    // Register stage: Q, TC and OVF all update one edge after the inputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q   <= RST_Q;
            TC  <= 1'b0;
            OVF <= 1'b0;
        end else begin
            if (EN) begin
                Q <= q_nxt;
            end
            TC  <= EN & ev;
            OVF <= (EN & ev) | (OVF & ~OVF_CLR);
        end
    end

endmodule
